// File: rtl/hsi_link_sequencer.sv
// rtl/hsi_link_sequencer.sv - HSI master transaction sequencer: issue, grade, retry, service poll, busy holdoff
module hsi_link_sequencer #(
    parameter int TIMEOUT_CYC  = 4096,
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_HOLDOFF = 256
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        host_req_i,
    input  logic [15:0] host_len_i,
    output logic        host_ack_o,
    output logic        tx_start_o,
    output logic [15:0] tx_len_o,
    output logic        tx_svc_o,
    input  logic        tx_done_i,
    input  logic        rx_frame_end_i,
    input  logic [5:0]  rx_errs_i,
    input  logic        rx_service_req_i,
    input  logic        rx_sd_busy_i,
    output logic        done_o,
    output logic [1:0]  res_code_o,
    output logic [5:0]  res_errs_o,
    output logic        res_svc_o,
    output logic [2:0]  retry_cnt_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLDOFF,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RX,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] HO_LAST   = 16'(BUSY_HOLDOFF - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  retry_q;
    logic        svc_pend_q;
    logic        hold_flag_q;
    logic [5:0]  lat_errs_q;
    logic        lat_svc_q;
    logic        lat_busy_q;
    logic        lat_to_q;
    logic [15:0] tx_len_q;
    logic        tx_svc_q;
    logic        host_ack_q;
    logic        tx_start_q;
    logic        done_q;
    logic [1:0]  res_code_q;
    logic [5:0]  res_errs_q;
    logic        res_svc_q;
    logic        busy_q;

    // Single registered FSM; pulse outputs default low and are raised on the edge entering their state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            svc_pend_q  <= 1'b0;
            hold_flag_q <= 1'b0;
            lat_errs_q  <= '0;
            lat_svc_q   <= 1'b0;
            lat_busy_q  <= 1'b0;
            lat_to_q    <= 1'b0;
            tx_len_q    <= '0;
            tx_svc_q    <= 1'b0;
            host_ack_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            done_q      <= 1'b0;
            res_code_q  <= '0;
            res_errs_q  <= '0;
            res_svc_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (svc_pend_q || host_req_i) begin
                        if (svc_pend_q) begin
                            tx_len_q <= '0;
                            tx_svc_q <= 1'b1;
                        end else begin
                            tx_len_q   <= host_len_i;
                            tx_svc_q   <= 1'b0;
                            host_ack_q <= 1'b1;
                        end
                        retry_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        if (hold_flag_q) begin
                            state_q <= S_HOLDOFF;
                        end else begin
                            state_q    <= S_SEND;
                            tx_start_q <= 1'b1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == HO_LAST) begin
                        cnt_q       <= '0;
                        hold_flag_q <= 1'b0;
                        state_q     <= S_SEND;
                        tx_start_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_done_i) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    // A frame end arriving on the expiry edge still counts as a reply.
                    if (rx_frame_end_i) begin
                        lat_errs_q <= rx_errs_i;
                        lat_svc_q  <= rx_service_req_i;
                        lat_busy_q <= rx_sd_busy_i;
                        lat_to_q   <= 1'b0;
                        state_q    <= S_EVAL;
                    end else if (cnt_q == TO_LAST) begin
                        lat_errs_q <= '0;
                        lat_svc_q  <= 1'b0;
                        lat_busy_q <= 1'b0;
                        lat_to_q   <= 1'b1;
                        state_q    <= S_EVAL;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_EVAL: begin
                    if (lat_errs_q[0] || retry_q >= RETRY_MAX) begin
                        if (lat_errs_q[0]) begin
                            res_code_q  <= 2'd0;
                            hold_flag_q <= hold_flag_q | lat_busy_q;
                            svc_pend_q  <= (svc_pend_q & ~tx_svc_q) | lat_svc_q;
                        end else begin
                            res_code_q <= lat_to_q ? 2'd2 : 2'd1;
                            svc_pend_q <= svc_pend_q & ~tx_svc_q;
                        end
                        res_errs_q <= lat_errs_q;
                        res_svc_q  <= tx_svc_q;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        retry_q    <= retry_q + 3'd1;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign host_ack_o  = host_ack_q;
    assign tx_start_o  = tx_start_q;
    assign tx_len_o    = tx_len_q;
    assign tx_svc_o    = tx_svc_q;
    assign done_o      = done_q;
    assign res_code_o  = res_code_q;
    assign res_errs_o  = res_errs_q;
    assign res_svc_o   = res_svc_q;
    assign retry_cnt_o = retry_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_hsi_link_sequencer.sv
// tb/tb_hsi_link_sequencer.sv - directed self-checking bench for hsi_link_sequencer
module tb_hsi_link_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        host_req = 1'b0;
    logic [15:0] host_len = '0;
    logic        host_ack;
    logic        tx_start;
    logic [15:0] tx_len;
    logic        tx_svc;
    logic        tx_done = 1'b0;
    logic        rx_frame_end = 1'b0;
    logic [5:0]  rx_errs = '0;
    logic        rx_service_req = 1'b0;
    logic        rx_sd_busy = 1'b0;
    logic        done;
    logic [1:0]  res_code;
    logic [5:0]  res_errs;
    logic        res_svc;
    logic [2:0]  retry_cnt;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_ack = 0;
    int n_done = 0;

    hsi_link_sequencer #(
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (3),
        .BUSY_HOLDOFF(8)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .host_req_i      (host_req),
        .host_len_i      (host_len),
        .host_ack_o      (host_ack),
        .tx_start_o      (tx_start),
        .tx_len_o        (tx_len),
        .tx_svc_o        (tx_svc),
        .tx_done_i       (tx_done),
        .rx_frame_end_i  (rx_frame_end),
        .rx_errs_i       (rx_errs),
        .rx_service_req_i(rx_service_req),
        .rx_sd_busy_i    (rx_sd_busy),
        .done_o          (done),
        .res_code_o      (res_code),
        .res_errs_o      (res_errs),
        .res_svc_o       (res_svc),
        .retry_cnt_o     (retry_cnt),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start) n_start++;
        if (host_ack) n_ack++;
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sigv(input int w);
        case (w)
            0:       return tx_start;
            1:       return done;
            default: return host_ack;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sigv(which) && n < budget);
        if (!sigv(which)) chk({tag, "_bound"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic reply(input logic [5:0] errs, input logic svc, input logic sdb);
        rx_frame_end   = 1'b1;
        rx_errs        = errs;
        rx_service_req = svc;
        rx_sd_busy     = sdb;
        tick();
        rx_frame_end   = 1'b0;
        rx_errs        = '0;
        rx_service_req = 1'b0;
        rx_sd_busy     = 1'b0;
    endtask

    // Accept a host frame with no holdoff: ack and start appear right after the sampling edge.
    task automatic start_host(input logic [15:0] len);
        host_req = 1'b1;
        host_len = len;
        tick();
        host_req = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int a0;
        int d0;

        tick();
        tick();
        chk("rst_outputs", {host_ack, tx_start, tx_len, tx_svc, done, res_code, res_errs, res_svc, retry_cnt, busy}, 32'd0);
        n_rst = 1'b1;
        tick();

        // Clean host transfer
        s0 = n_start; a0 = n_ack;
        start_host(16'd5);
        chk("clean_ack", host_ack, 1);
        chk("clean_start", tx_start, 1);
        chk("clean_len", tx_len, 5);
        chk("clean_svc", tx_svc, 0);
        chk("clean_busy", busy, 1);
        tick();
        chk("clean_start_pulse", tx_start, 0);
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b0);
        chk("clean_eval_nodone", done, 0);
        tick();
        chk("clean_done", done, 1);
        chk("clean_code", res_code, 0);
        chk("clean_errs", res_errs, 6'b000001);
        chk("clean_retry", retry_cnt, 0);
        tick();
        chk("clean_done_pulse", done, 0);
        chk("clean_idle", busy, 0);
        chk("clean_nstart", n_start - s0, 1);
        chk("clean_nack", n_ack - a0, 1);

        // CRC error then OK
        s0 = n_start;
        start_host(16'd7);
        tick();
        pulse_tx_done();
        tick();
        reply(6'b100000, 1'b0, 1'b0);
        tick();
        chk("crc_retry_start", tx_start, 1);
        chk("crc_retry_cnt", retry_cnt, 1);
        chk("crc_retry_len", tx_len, 7);
        tick();
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b0);
        tick();
        chk("crc_done", done, 1);
        chk("crc_code", res_code, 0);
        chk("crc_retry_final", retry_cnt, 1);
        chk("crc_nstart", n_start - s0, 2);
        tick();

        // Timeout on every attempt
        s0 = n_start;
        start_host(16'd3);
        for (int a = 0; a < 4; a++) begin
            tick();
            pulse_tx_done();
            if (a < 3) begin
                wait_for("to_start", 0, 100, n);
                chk("to_gap_start", n, 17);
                chk("to_retry_cnt", retry_cnt, a + 1);
            end else begin
                wait_for("to_done", 1, 100, n);
                chk("to_gap_done", n, 17);
            end
        end
        chk("to_code", res_code, 2);
        chk("to_errs", res_errs, 0);
        chk("to_retry_final", retry_cnt, 3);
        chk("to_nstart", n_start - s0, 4);
        tick();

        // Service request while a host request is pending
        start_host(16'd9);
        tick();
        pulse_tx_done();
        tick();
        host_req = 1'b1;
        host_len = 16'd12;
        a0 = n_ack;
        reply(6'b000001, 1'b1, 1'b0);
        tick();
        chk("svc_host_done", done, 1);
        chk("svc_host_ressvc", res_svc, 0);
        tick();
        tick();
        chk("poll_start", tx_start, 1);
        chk("poll_svc", tx_svc, 1);
        chk("poll_len", tx_len, 0);
        chk("poll_noack", n_ack - a0, 0);
        tick();
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b0);
        tick();
        chk("poll_done", done, 1);
        chk("poll_ressvc", res_svc, 1);
        tick();
        tick();
        chk("svc_after_ack", host_ack, 1);
        chk("svc_after_start", tx_start, 1);
        chk("svc_after_len", tx_len, 12);
        chk("svc_after_svc", tx_svc, 0);
        host_req = 1'b0;
        tick();
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b0);
        tick();
        chk("svc_after_ressvc", res_svc, 0);
        tick();

        // SD busy holdoff
        start_host(16'd4);
        tick();
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b1);
        tick();
        tick();
        host_req = 1'b1;
        host_len = 16'd6;
        tick();
        host_req = 1'b0;
        chk("hold_ack", host_ack, 1);
        chk("hold_nostart", tx_start, 0);
        chk("hold_busy", busy, 1);
        wait_for("hold_start", 0, 50, n);
        chk("hold_cycles", n, 8);
        tick();
        pulse_tx_done();
        tick();
        reply(6'b000001, 1'b0, 1'b0);
        tick();
        tick();

        // Frame end on the expiry edge; holdoff must no longer apply
        start_host(16'd2);
        chk("edge_start_nohold", tx_start, 1);
        tick();
        pulse_tx_done();
        for (int i = 0; i < 15; i++) tick();
        reply(6'b000001, 1'b0, 1'b0);
        tick();
        chk("edge_done", done, 1);
        chk("edge_nostart", tx_start, 0);
        chk("edge_code", res_code, 0);
        chk("edge_retry", retry_cnt, 0);
        tick();

        // Reset during WAIT_RX with host_req held
        start_host(16'd1);
        tick();
        pulse_tx_done();
        tick();
        host_req = 1'b1;
        host_len = 16'd33;
        d0 = n_done;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_outputs", {host_ack, tx_start, tx_len, tx_svc, done, res_code, res_errs, res_svc, retry_cnt, busy}, 32'd0);
        rx_frame_end = 1'b1;
        rx_errs = 6'b000001;
        tick();
        rx_frame_end = 1'b0;
        rx_errs = '0;
        n_rst = 1'b1;
        tick();
        chk("rst_reack", host_ack, 1);
        chk("rst_restart", tx_start, 1);
        chk("rst_len", tx_len, 33);
        host_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_nodone", n_done - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hsi_link_sequencer.md
# hsi_link_sequencer

Master-side transaction sequencer for the HSI serial link. It accepts transaction requests from the host and issues them to the TX framer. It then waits for the slave reply, which the RX error checker reports through the `rx_frame_end` / `rx_errs` / `rx_service_req` / `rx_sd_busy` outputs, and grades each reply. Failed attempts are retried, service polls are scheduled when the slave requests them, and the next frame is held off while the slave's SD is busy.

## Interface
- `TIMEOUT_CYC`, 4096: clk cycles allowed between `tx_done` and `rx_frame_end`; 16-bit counter, range 1..65535.
- `MAX_RETRY`, 3: retries after the first attempt, range 0..7.
- `BUSY_HOLDOFF`, 256: idle cycles inserted before the next frame after the slave reported SD busy; 16-bit, range 1..65535.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `host_req`  in  1  level; host transaction request, held until `host_ack`.
- `host_len`  in  16  payload byte count N for the host frame.
- `host_ack`  out  1  one-cycle pulse; host request accepted, `host_len` captured.
- `tx_start`  out  1  one-cycle pulse to the framer.
- `tx_len`  out  16  payload length; stable from `tx_start` until `done`.
- `tx_svc`  out  1  1 = service-poll frame; stable like `tx_len`.
- `tx_done`  in  1  one-cycle pulse; framer sent the last byte.
- `rx_frame_end`  in  1  reply frame complete; `rx_errs` is valid only in this cycle.
- `rx_errs`  in  6  [0] ok, [1] marker, [2] status, [3] N, [4] parity, [5] crc.
- `rx_service_req`  in  1  slave service request flag.
- `rx_sd_busy`  in  1  slave SD busy flag.
- `done`  out  1  one-cycle pulse; transaction finished.
- `res_code`  out  2  0 OK, 1 FRAME_ERR, 2 TIMEOUT; held until the next `done`.
- `res_errs`  out  6  `rx_errs` of the last attempt; 0 on timeout.
- `res_svc`  out  1  result belongs to a service poll.
- `retry_cnt`  out  3  retries used by the current or last transaction.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, HOLDOFF, SEND, WAIT_TX, WAIT_RX, EVAL, DONE. Moore outputs, all registered.
- **IDLE, choosing the next frame:**
  - If `svc_pend`=1, select a service poll: `tx_len`=0, `tx_svc`=1, no `host_ack`.
  - Else if `host_req`=1, select a host frame: capture `host_len` into `tx_len`, `tx_svc`=0, pulse `host_ack`.
  - A service poll has priority over a host request.
  - Next state is HOLDOFF if `hold_flag`=1, else SEND. `retry_cnt` clears.
- **HOLDOFF:** counts `BUSY_HOLDOFF` cycles, clears `hold_flag`, then goes to SEND.
- **SEND:** `tx_start`=1 for this single cycle, then WAIT_TX.
- **WAIT_TX:** waits indefinitely for `tx_done`, then WAIT_RX. The timeout counter clears on entry to WAIT_RX.
- **WAIT_RX:**
  - `rx_frame_end`=1: latch `rx_errs`, `rx_service_req` and `rx_sd_busy`, then EVAL.
  - Counter reaches `TIMEOUT_CYC` first: mark the attempt as a timeout (`res_errs`=0), then EVAL.
  - `rx_frame_end` in the same cycle as expiry: the frame wins.
- **EVAL:**
  - `rx_errs[0]`=1: `res_code`=0, go to DONE.
    - Set `hold_flag` if `sd_busy` was latched.
    - Set `svc_pend` if the service request was latched.
  - Attempt failed and `retry_cnt` < `MAX_RETRY`: increment `retry_cnt`, go to SEND (same `tx_len` / `tx_svc`).
  - Attempt failed and retries are exhausted: `res_code` = 1 (frame error) or 2 (timeout), go to DONE.
- **DONE:**
  - `done`=1 for one cycle; `res_svc` = `tx_svc`.
  - If the frame was a service poll, clear `svc_pend` regardless of outcome, unless EVAL re-set it on an OK reply.
  - Return to IDLE.
- `rx_frame_end` outside WAIT_RX is ignored; there is no flag update.
- Reset mid-operation:
  - FSM returns to IDLE; `svc_pend`, `hold_flag` and counters clear.
  - Any outstanding framer or reply activity is ignored.
  - A `host_req` still held after reset is accepted anew.

## Timing
- Reset values:
  - All outputs are 0.
  - `res_code`=0 and `res_errs`=0; these are valid only once `done` has pulsed.
- IDLE samples `host_req`=1 at edge k. In cycle k..k+1, `host_ack`=1 and `tx_start`=1 together when there is no holdoff.
- A `host_req` still high at edge k+1 is not re-accepted.
- `tx_done` at edge t starts the timeout window. Timeout is declared at edge t+`TIMEOUT_CYC` if no frame end has arrived.
- `rx_frame_end` at edge r: EVAL occupies r..r+1. DONE, or SEND for a retry, occupies r+1..r+2.
- `done` to the next `tx_start` with no holdoff: 2 cycles (DONE → IDLE → SEND). With holdoff: `BUSY_HOLDOFF`+2.
- `res_*` outputs update on the edge entering DONE and hold until the next DONE.

## Test plan
- **Clean host transfer:** `host_req` with `host_len`=5; `tx_done`; `rx_frame_end` with `rx_errs`=6'b000001 → one `host_ack`, one `tx_start`, `tx_len`=5, `done` with `res_code`=0, `retry_cnt`=0.
- **CRC retry then OK:** first reply `rx_errs`=6'b100000, second reply 6'b000001 → two `tx_start` pulses, `retry_cnt`=1, `res_code`=0.
- **Timeout exhaustion** (`MAX_RETRY`=3, `TIMEOUT_CYC`=16): never assert `rx_frame_end` → four `tx_start` pulses, each timeout 16 cycles after `tx_done`, `res_code`=2, `res_errs`=0.
- **Service request:** OK reply with `rx_service_req`=1 while `host_req` is pending → next frame is a poll (`tx_svc`=1, `tx_len`=0, no `host_ack`), `res_svc`=1; the host frame follows afterwards.
- **SD busy** (`BUSY_HOLDOFF`=8): OK reply with `rx_sd_busy`=1, then a new `host_req` → `host_ack`, then exactly 8 HOLDOFF cycles before `tx_start`.
- **Boundary cases:**
  - `rx_frame_end` in the same cycle as timeout expiry → treated as a frame.
  - `n_rst` pulse during WAIT_RX → all outputs 0, no `done`; the held `host_req` is re-acked after reset.
